// File: rtl/axi_hp_burst_reader.sv
// AXI3/AXI4 HP-port INCR burst read engine with multiple outstanding bursts.
// Streams returned beats with one-cycle latency and flags protocol errors.
module axi_hp_burst_reader #(
    parameter int BURST_SIZE      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_BITS       = 29,
    parameter int MAX_OUTSTANDING = 2,
    parameter int AXI4            = 0,
    localparam int LEN_W          = (AXI4 != 0) ? 8 : 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_BITS-1:0]  DMA_RD_ADDR,
    input  logic                  DMA_START,
    output logic                  DMA_READY,
    output logic [DATA_WIDTH-1:0] DMA_RD_DATA,
    output logic                  DMA_RD_DATA_VALID,
    output logic                  DMA_RD_LAST,
    output logic                  DMA_ERROR,
    input  logic                  DMA_ERROR_CLEAR,
    input  logic                  m00_axi_arready,
    output logic [31:0]           m00_axi_araddr,
    output logic [LEN_W-1:0]      m00_axi_arlen,
    output logic [2:0]            m00_axi_arsize,
    output logic [1:0]            m00_axi_arburst,
    output logic                  m00_axi_arvalid,
    input  logic                  m00_axi_rvalid,
    input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
    input  logic [1:0]            m00_axi_rresp,
    input  logic                  m00_axi_rlast,
    output logic                  m00_axi_rready
);

    localparam int SZ = (DATA_WIDTH == 64) ? 3 : 2;
    localparam int PW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_SIZE - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_OUTSTANDING);

    logic                  arvalid_q, arvalid_d;
    logic [31:0]           araddr_q, araddr_d;
    logic                  rready_q;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic [PW-1:0]         pend_q, pend_d;
    logic [BW-1:0]         beat_q, beat_d;

    logic accept;
    logic r_hs;
    logic beat_end;
    logic pend_dec;
    logic err_set;

    assign DMA_READY = RESET & ~arvalid_q & (pend_q < PEND_MAX);
    assign accept    = DMA_START & DMA_READY;
    assign r_hs      = m00_axi_rvalid & rready_q;
    assign beat_end  = (beat_q == BEAT_LAST);
    assign pend_dec  = r_hs & m00_axi_rlast & (pend_q != '0);
    assign err_set   = r_hs & ((m00_axi_rresp != 2'b00)
                             | (m00_axi_rlast != beat_end)
                             | (pend_q == '0));

    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_araddr  = araddr_q;
    assign m00_axi_arlen   = LEN_W'(BURST_SIZE - 1);
    assign m00_axi_arsize  = 3'(SZ);
    assign m00_axi_arburst = 2'b01;
    assign m00_axi_rready  = rready_q;

    assign DMA_RD_DATA       = data_q;
    assign DMA_RD_DATA_VALID = valid_q;
    assign DMA_RD_LAST       = last_q;
    assign DMA_ERROR         = err_q;

    // Next-state for AR request, outstanding count, beat tracking and error flag
    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        if (accept) begin
            arvalid_d = 1'b1;
            araddr_d  = 32'({DMA_RD_ADDR, {SZ{1'b0}}});
        end else if (arvalid_q && m00_axi_arready) begin
            arvalid_d = 1'b0;
        end

        pend_d = pend_q;
        if (accept && !pend_dec) begin
            pend_d = pend_q + 1'b1;
        end else if (!accept && pend_dec) begin
            pend_d = pend_q - 1'b1;
        end

        data_d  = r_hs ? m00_axi_rdata : data_q;
        valid_d = r_hs;
        last_d  = r_hs & beat_end;

        beat_d = beat_q;
        if (r_hs) begin
            beat_d = beat_end ? '0 : beat_q + 1'b1;
        end

        // A new error in the same cycle as a clear must survive.
        err_d = err_set | (err_q & ~DMA_ERROR_CLEAR);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            pend_q    <= '0;
            beat_q    <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= 1'b1;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            beat_q    <= beat_d;
        end
    end

endmodule

// File: tb/tb_axi_hp_burst_reader.sv
// Scoreboard bench for axi_hp_burst_reader.
// Default config plus an AXI4/64-bit instance for AR field checks.
module tb_axi_hp_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [28:0] addr;
    logic        start;
    logic        ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        err;
    logic        clr;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rready;

    logic [28:0] addr2;
    logic        start2;
    logic        ready2;
    logic [63:0] rd_data2;
    logic        rd_valid2;
    logic        rd_last2;
    logic        err2;
    logic [31:0] araddr2;
    logic [7:0]  arlen2;
    logic [2:0]  arsize2;
    logic [1:0]  arburst2;
    logic        arvalid2;
    logic        rready2;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ar_cnt = 0;
    int   mb = 0;

    always #5 clk = ~clk;

    axi_hp_burst_reader u_dut (
        .CLK               (clk),
        .RESET             (rst_n),
        .DMA_RD_ADDR       (addr),
        .DMA_START         (start),
        .DMA_READY         (ready),
        .DMA_RD_DATA       (rd_data),
        .DMA_RD_DATA_VALID (rd_valid),
        .DMA_RD_LAST       (rd_last),
        .DMA_ERROR         (err),
        .DMA_ERROR_CLEAR   (clr),
        .m00_axi_arready   (arready),
        .m00_axi_araddr    (araddr),
        .m00_axi_arlen     (arlen),
        .m00_axi_arsize    (arsize),
        .m00_axi_arburst   (arburst),
        .m00_axi_arvalid   (arvalid),
        .m00_axi_rvalid    (rvalid),
        .m00_axi_rdata     (rdata),
        .m00_axi_rresp     (rresp),
        .m00_axi_rlast     (rlast),
        .m00_axi_rready    (rready)
    );

    axi_hp_burst_reader #(
        .BURST_SIZE (16),
        .DATA_WIDTH (64),
        .AXI4       (1)
    ) u_dut4 (
        .CLK               (clk),
        .RESET             (rst_n),
        .DMA_RD_ADDR       (addr2),
        .DMA_START         (start2),
        .DMA_READY         (ready2),
        .DMA_RD_DATA       (rd_data2),
        .DMA_RD_DATA_VALID (rd_valid2),
        .DMA_RD_LAST       (rd_last2),
        .DMA_ERROR         (err2),
        .DMA_ERROR_CLEAR   (1'b0),
        .m00_axi_arready   (1'b1),
        .m00_axi_araddr    (araddr2),
        .m00_axi_arlen     (arlen2),
        .m00_axi_arsize    (arsize2),
        .m00_axi_arburst   (arburst2),
        .m00_axi_arvalid   (arvalid2),
        .m00_axi_rvalid    (1'b0),
        .m00_axi_rdata     (64'd0),
        .m00_axi_rresp     (2'b00),
        .m00_axi_rlast     (1'b0),
        .m00_axi_rready    (rready2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rbeat(input logic [31:0] d, input logic l,
                         input logic [1:0] resp);
        rvalid = 1'b1;
        rdata  = d;
        rlast  = l;
        rresp  = resp;
        sbq.push_back({d, (mb == 7)});
        mb = (mb == 7) ? 0 : mb + 1;
        cyc(1);
    endtask

    task automatic burst(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            rbeat(base + 32'(i), (i == 7), 2'b00);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic request(input logic [28:0] a);
        addr  = a;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    // Output monitor: every valid beat must match the oldest expected beat
    always @(posedge clk) begin
        #1;
        if (rd_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check_eq("unexp_beat", rd_valid, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check_eq("rd_data", rd_data, e.d);
                check_eq("rd_last", rd_last, e.l);
            end
        end
    end

    // Count AR handshakes
    always @(posedge clk) begin
        if (arvalid && arready) ar_cnt++;
    end

    initial begin
        int ar0;
        rst_n   = 1'b0;
        addr    = '0;
        start   = 1'b0;
        clr     = 1'b0;
        arready = 1'b1;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        addr2   = '0;
        start2  = 1'b0;
        cyc(2);
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_araddr", araddr, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_valid", rd_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ready", ready, 0);
        rst_n = 1'b1;
        cyc(1);
        check_eq("rel_ready", ready, 1);
        check_eq("rel_rready", rready, 1);

        addr  = 29'h100;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_eq("t1_arvalid", arvalid, 1);
        check_eq("t1_araddr", araddr, 32'h400);
        check_eq("t1_arlen", arlen, 7);
        check_eq("t1_arsize", arsize, 2);
        check_eq("t1_arburst", arburst, 1);
        check_eq("t1_ready_busy", ready, 0);
        cyc(1);
        check_eq("t1_ar_done", arvalid, 0);
        check_eq("t1_ready_back", ready, 1);
        burst(32'hA0);
        cyc(1);
        check_eq("t1_valid_idle", rd_valid, 0);
        check_eq("t1_no_err", err, 0);

        ar0 = ar_cnt;
        request(29'h200);
        check_eq("t2_ready1", ready, 1);
        request(29'h280);
        check_eq("t2_full", ready, 0);
        addr  = 29'h300;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_eq("t2_ignored", arvalid, 0);
        check_eq("t2_ar_cnt", ar_cnt - ar0, 2);
        burst(32'hB0);
        check_eq("t2_ready_after", ready, 1);
        addr  = 29'h300;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check_eq("t2_third_av", arvalid, 1);
        check_eq("t2_third_addr", araddr, 32'hC00);
        cyc(1);
        burst(32'hC0);
        burst(32'hD0);

        arready = 1'b0;
        addr    = 29'h20;
        start   = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            addr  = 29'h30 + 29'(i);
            start = 1'b1;
            cyc(1);
            check_eq("t3_arvalid", arvalid, 1);
            check_eq("t3_araddr", araddr, 32'h80);
            check_eq("t3_ready", ready, 0);
        end
        start   = 1'b0;
        arready = 1'b1;
        cyc(1);
        check_eq("t3_released", arvalid, 0);
        burst(32'hE0);

        request(29'h40);
        for (int i = 0; i < 8; i++) begin
            rbeat(32'hF0 + 32'(i), (i == 4), 2'b00);
            if (i == 3) check_eq("t4_err_pre", err, 0);
            if (i == 4) check_eq("t4_err_early", err, 1);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        cyc(2);
        check_eq("t4_err_sticky", err, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check_eq("t4_err_clr", err, 0);

        request(29'h50);
        for (int i = 0; i < 8; i++) begin
            rbeat(32'h60 + 32'(i), (i == 7), (i == 2) ? 2'b10 : 2'b00);
            if (i == 1) check_eq("t5_err_pre", err, 0);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        check_eq("t5_err_resp", err, 1);
        clr = 1'b1;
        cyc(1);
        check_eq("t5_err_clr", err, 0);
        rbeat(32'h77, 1'b0, 2'b00);
        rvalid = 1'b0;
        clr    = 1'b0;
        check_eq("t5_set_wins", err, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check_eq("t5_err_clr2", err, 0);

        request(29'h600);
        for (int i = 0; i < 3; i++) begin
            rbeat(32'h90 + 32'(i), 1'b0, 2'b00);
        end
        rvalid = 1'b0;
        rst_n  = 1'b0;
        cyc(1);
        mb = 0;
        check_eq("t6_arvalid", arvalid, 0);
        check_eq("t6_araddr", araddr, 0);
        check_eq("t6_rready", rready, 0);
        check_eq("t6_valid", rd_valid, 0);
        check_eq("t6_last", rd_last, 0);
        check_eq("t6_data", rd_data, 0);
        check_eq("t6_err", err, 0);
        check_eq("t6_ready", ready, 0);
        rst_n = 1'b1;
        cyc(1);
        check_eq("t6_ready_rel", ready, 1);
        rbeat(32'h55, 1'b0, 2'b00);
        rvalid = 1'b0;
        check_eq("t6_stray_err", err, 1);
        cyc(1);

        addr2  = 29'h10;
        start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        check_eq("t7_arvalid", arvalid2, 1);
        check_eq("t7_araddr", araddr2, 32'h80);
        check_eq("t7_arlen", arlen2, 15);
        check_eq("t7_arsize", arsize2, 3);
        check_eq("t7_arburst", arburst2, 1);
        cyc(2);

        check_eq("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
